// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequence controller.
package lfsr_pkg;

  // Default LFSR width and its maximal-length period (2^8 - 1).
  localparam int LFSR_W_DEF = 8;
  localparam int PERIOD     = 255;

  // An all-zero seed locks a Fibonacci LFSR, so it is replaced by this value.
  localparam int SEED_SUB   = 1;

  // Controller states.
  //   state    | meaning
  //   ST_IDLE  | stopped, strobes low, waiting for start
  //   ST_LOAD  | single cycle: present seed and pulse lfsr_load
  //   ST_RUN   | advance LFSR once per prescaler tick
  //   ST_PAUSE | prescaler frozen, step gives single advances
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, ticks on the last count and wraps.
// Holds its count when disabled; synchronous clear restarts it from 0.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // Count while enabled, wrap after the terminal count, freeze otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run/pause/step controller for an external Fibonacci LFSR.
// Every output is a register: a command seen in cycle N shows up on the
// strobes in cycle N+1, and the external LFSR acts on it at the next edge.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int LFSR_W   = LFSR_W_DEF
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [LFSR_W-1:0] sw,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [LFSR_W-1:0] lfsr_q,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  output logic              running,
  output logic [LFSR_W-1:0] step_cnt,
  output logic              period_done,
  output logic              seq_err
);

  localparam logic [LFSR_W-1:0] LAST_STEP = LFSR_W'(PERIOD - 1);
  localparam logic [LFSR_W-1:0] SEED_ALT  = LFSR_W'(SEED_SUB);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_adv;
  logic              w_load;
  logic              w_tick;
  logic              w_tick_en;
  logic              w_tick_clr;

  logic              r_load;
  logic              r_en;
  logic              r_running;
  logic [LFSR_W-1:0] r_seed;
  logic [LFSR_W-1:0] r_step_cnt;
  logic              r_wrap_pend;
  logic              r_period_done;
  logic              r_seq_err;

  // The prescaler only runs in RUN; a stop in the tick cycle also freezes it,
  // so a later resume fires that suppressed tick straight away.
  assign w_tick_en  = (r_state == ST_RUN) && !stop;
  assign w_tick_clr = (r_state == ST_LOAD);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk  (clk_50m),
    .i_rst  (rst),
    .i_en   (w_tick_en),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and advance decision; stop beats start beats step everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!stop && start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_adv = w_tick;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          w_state_nxt = ST_RUN;
        end else if (step) begin
          w_adv = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_load = (w_state_nxt == ST_LOAD);

  // Strobes and status track the state being entered, so they line up with it.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_load        <= 1'b0;
      r_en          <= 1'b0;
      r_running     <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_load        <= w_load;
      r_en          <= w_adv;
      r_running     <= (w_state_nxt == ST_RUN);
      r_period_done <= r_wrap_pend && !w_load;
    end
  end

  // Seed capture; zero is substituted because it would lock the LFSR.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_seed <= '0;
    end else if (w_load) begin
      r_seed <= (sw == '0) ? SEED_ALT : sw;
    end
  end

  // Advance counter; the 255th advance wraps it and arms period_done, which
  // then lands in the cycle where lfsr_q already shows that advance.
  always_ff @(posedge clk_50m) begin
    if (rst || w_load) begin
      r_step_cnt  <= '0;
      r_wrap_pend <= 1'b0;
    end else if (w_adv) begin
      if (r_step_cnt == LAST_STEP) begin
        r_step_cnt  <= '0;
        r_wrap_pend <= 1'b1;
      end else begin
        r_step_cnt  <= r_step_cnt + 1'b1;
        r_wrap_pend <= 1'b0;
      end
    end else begin
      r_wrap_pend <= 1'b0;
    end
  end

  // Sticky period check: after a full period the LFSR must be back at its seed.
  always_ff @(posedge clk_50m) begin
    if (rst || w_load) begin
      r_seq_err <= 1'b0;
    end else if (r_period_done && (lfsr_q != r_seed)) begin
      r_seq_err <= 1'b1;
    end
  end

  assign lfsr_load   = r_load;
  assign lfsr_seed   = r_seed;
  assign lfsr_en     = r_en;
  assign running     = r_running;
  assign step_cnt    = r_step_cnt;
  assign period_done = r_period_done;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with TICK_DIV=4 and an 8-bit Fibonacci
// LFSR model (taps 8,6,5,4) closing the loop on lfsr_q.
module tb_lfsr_seq_ctrl;

  logic       clk_50m;
  logic       rst;
  logic [7:0] sw;
  logic       start;
  logic       stop;
  logic       step;
  logic [7:0] lfsr_q;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic       lfsr_en;
  logic       running;
  logic [7:0] step_cnt;
  logic       period_done;
  logic       seq_err;

  logic [7:0] r_model_q;
  logic       force_ff;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  lfsr_seq_ctrl #(
    .TICK_DIV (4),
    .LFSR_W   (8)
  ) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .sw          (sw),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .lfsr_q      (lfsr_q),
    .lfsr_load   (lfsr_load),
    .lfsr_seed   (lfsr_seed),
    .lfsr_en     (lfsr_en),
    .running     (running),
    .step_cnt    (step_cnt),
    .period_done (period_done),
    .seq_err     (seq_err)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  // External LFSR: load on lfsr_load, shift left with x^8+x^6+x^5+x^4+1 feedback.
  always @(posedge clk_50m) begin
    if (rst) begin
      r_model_q <= 8'h00;
    end else if (lfsr_load) begin
      r_model_q <= lfsr_seed;
    end else if (lfsr_en) begin
      r_model_q <= {r_model_q[6:0], r_model_q[7] ^ r_model_q[5] ^ r_model_q[4] ^ r_model_q[3]};
    end
  end

  assign lfsr_q = force_ff ? 8'hFF : r_model_q;

  task automatic cyc();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {11'd0, lfsr_load, lfsr_en, running, period_done, seq_err, step_cnt, lfsr_seed};
  endfunction

  initial begin
    logic [11:0] en_pat;
    int          en_cnt;
    int          ld_cnt;
    int          pd_cnt;
    int          pd_at;
    logic [7:0]  pd_step;
    logic [7:0]  sc_pre;

    rst = 1'b1; sw = 8'h00; start = 1'b0; stop = 1'b0; step = 1'b0; force_ff = 1'b0;
    cyc();
    cyc();
    chk("reset_outputs", all_out(), 32'd0);

    // Load 0x01 and run: strobe every 4th cycle, first one 4 cycles into RUN.
    rst = 1'b0; sw = 8'h01;
    start = 1'b1; cyc(); start = 1'b0;
    chk("load_strobe", {31'd0, lfsr_load}, 32'd1);
    chk("load_seed", {24'd0, lfsr_seed}, 32'h01);
    chk("load_not_running", {31'd0, running}, 32'd0);
    cyc();
    chk("load_one_cycle", {31'd0, lfsr_load}, 32'd0);
    chk("run_running", {31'd0, running}, 32'd1);
    en_pat = '0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      en_pat[i-1] = lfsr_en;
    end
    chk("run_en_pattern", {20'd0, en_pat}, 32'h888);
    chk("run_step_cnt_12", {24'd0, step_cnt}, 32'd3);
    for (int i = 0; i < 8; i++) cyc();
    chk("run_step_cnt_20", {24'd0, step_cnt}, 32'd5);

    // Pause at step_cnt=5, then three manual steps.
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("pause_running", {31'd0, running}, 32'd0);
    chk("pause_no_en", {31'd0, lfsr_en}, 32'd0);
    en_cnt = 0; ld_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; cyc(); step = 1'b0;
      en_cnt += int'(lfsr_en); ld_cnt += int'(lfsr_load);
      cyc();
      en_cnt += int'(lfsr_en); ld_cnt += int'(lfsr_load);
    end
    chk("step_en_count", en_cnt, 32'd3);
    chk("step_no_load", ld_cnt, 32'd0);
    chk("step_cnt_8", {24'd0, step_cnt}, 32'd8);
    chk("step_not_running", {31'd0, running}, 32'd0);

    // Resume keeps the frozen tick count (0), so the next strobe is 4 cycles on.
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume_running", {31'd0, running}, 32'd1);
    en_pat = '0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      en_pat[i-1] = lfsr_en;
    end
    chk("resume_en_pattern", {28'd0, en_pat[3:0]}, 32'h8);
    chk("resume_step_cnt", {24'd0, step_cnt}, 32'd9);

    // Stop lands exactly on a tick cycle: no strobe, paused with count frozen at 3.
    cyc(); cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_tick_no_en", {31'd0, lfsr_en}, 32'd0);
    chk("stop_tick_paused", {31'd0, running}, 32'd0);
    chk("stop_tick_step_cnt", {24'd0, step_cnt}, 32'd9);
    step = 1'b1; cyc(); step = 1'b0;
    chk("stop_tick_step_en", {31'd0, lfsr_en}, 32'd1);
    chk("stop_tick_step_cnt10", {24'd0, step_cnt}, 32'd10);
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume2_first_en", {30'd0, running, lfsr_en}, 32'b10);
    cyc();
    chk("resume2_immediate_tick", {31'd0, lfsr_en}, 32'd1);
    chk("resume2_step_cnt", {24'd0, step_cnt}, 32'd11);

    // PAUSE -> IDLE, then step and start+stop are ignored in IDLE.
    stop = 1'b1; cyc(); stop = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("idle_not_running", {31'd0, running}, 32'd0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("idle_step_ignored", {30'd0, lfsr_en, lfsr_load}, 32'd0);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("idle_start_stop_no_load", {30'd0, lfsr_load, running}, 32'd0);
    cyc();
    chk("idle_start_stop_stays", {30'd0, lfsr_load, running}, 32'd0);

    // Zero seed is replaced by 1.
    sw = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    chk("zero_seed_load", {31'd0, lfsr_load}, 32'd1);
    chk("zero_seed_sub", {24'd0, lfsr_seed}, 32'h01);
    cyc();
    chk("zero_seed_held", {24'd0, lfsr_seed}, 32'h01);
    stop = 1'b1; cyc(); stop = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;

    // Full period from seed 0xA5: the LFSR returns to its seed, no error.
    sw = 8'hA5;
    start = 1'b1; cyc(); start = 1'b0;
    chk("period_seed", {24'd0, lfsr_seed}, 32'hA5);
    cyc();
    pd_cnt = 0; pd_at = 0; pd_step = 8'hFF; sc_pre = 8'h00;
    for (int i = 1; i <= 1030; i++) begin
      cyc();
      if (i == 1019) sc_pre = step_cnt;
      if (period_done) begin
        pd_cnt++;
        pd_at   = i;
        pd_step = step_cnt;
      end
    end
    chk("period_pre_wrap_cnt", {24'd0, sc_pre}, 32'd254);
    chk("period_pulse_count", pd_cnt, 32'd1);
    chk("period_pulse_cycle", pd_at, 32'd1021);
    chk("period_wrap_step_cnt", {24'd0, pd_step}, 32'd0);
    chk("period_no_err", {31'd0, seq_err}, 32'd0);

    // Same period with lfsr_q forced to 0xFF around the wrap: error is flagged and held.
    stop = 1'b1; cyc(); stop = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    pd_cnt = 0;
    for (int i = 1; i <= 1030; i++) begin
      cyc();
      if (period_done) pd_cnt++;
      if (i == 1020) force_ff = 1'b1;
      if (i == 1022) force_ff = 1'b0;
    end
    chk("forced_pulse_count", pd_cnt, 32'd1);
    chk("forced_seq_err", {31'd0, seq_err}, 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("forced_err_held_idle", {31'd0, seq_err}, 32'd1);

    // A new load clears the sticky error.
    sw = 8'h3C;
    start = 1'b1; cyc(); start = 1'b0;
    chk("reload_clears_err", {31'd0, seq_err}, 32'd0);
    chk("reload_seed", {24'd0, lfsr_seed}, 32'h3C);

    // Reset in the middle of RUN clears everything on that edge.
    for (int i = 0; i < 11; i++) cyc();
    chk("prereset_step_cnt", {24'd0, step_cnt}, 32'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrun_reset_outputs", all_out(), 32'd0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("post_reset_idle", all_out(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: clk_50m cycles per automatic LFSR step (1 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter LFSR_W, default 8: LFSR width; maximal-length period = 2^LFSR_W - 1 = 255.
REQ-003 SHALL have port clk_50m  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sw  in  LFSR_W  seed value from board switches, sampled only in LOAD.
REQ-006 SHALL have port start  in  1  one-cycle command pulse: load-and-run from IDLE, resume from PAUSE.
REQ-007 SHALL have port stop  in  1  one-cycle command pulse: pause from RUN, return to IDLE from PAUSE.
REQ-008 SHALL have port step  in  1  one-cycle command pulse: single LFSR advance while in PAUSE.
REQ-009 SHALL have port lfsr_q  in  LFSR_W  current state fed back from the external Fibonacci LFSR.
REQ-010 SHALL have port lfsr_load  out  1  one-cycle load strobe to the LFSR.
REQ-011 SHALL have port lfsr_seed  out  LFSR_W  seed presented to the LFSR; held stable until the next LOAD.
REQ-012 SHALL have port lfsr_en  out  1  one-cycle advance strobe to the LFSR.
REQ-013 SHALL have ports running (1, high in RUN), step_cnt (LFSR_W, advances since last load, 0..254), period_done (1, one-cycle pulse) and seq_err (1, sticky period mismatch flag), all outputs.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN and PAUSE.
REQ-015 SHALL, in IDLE, move to LOAD on start; step is ignored and all strobes stay low.
REQ-016 SHALL, in LOAD (exactly one cycle), assert lfsr_load, drive lfsr_seed = sw (or 1 if sw == 0, since all-zero locks the LFSR), clear step_cnt, tick counter and seq_err, then enter RUN.
REQ-017 SHALL, in RUN, assert lfsr_en for one cycle on every tick; the first tick comes TICK_DIV cycles after entering RUN from LOAD.
REQ-018 SHALL, in RUN, move to PAUSE on stop with no lfsr_en that cycle, even if a tick coincides; start and step are ignored.
REQ-019 SHALL, in PAUSE, freeze the tick counter (no reset); step gives exactly one lfsr_en the same cycle; start resumes RUN keeping the tick count; stop moves to IDLE.
REQ-020 SHALL, on simultaneous commands, apply priority stop > start > step in every state.
REQ-021 SHALL implement the tick counter as 0..TICK_DIV-1, asserting tick when count == TICK_DIV-1 and enabled, then wrapping to 0.
REQ-022 SHALL increment step_cnt on every lfsr_en; on lfsr_en with step_cnt == 254, wrap step_cnt to 0 and pulse period_done on the next cycle.
REQ-023 SHALL, in the period_done cycle, compare lfsr_q with lfsr_seed and set seq_err on mismatch; seq_err holds until LOAD or rst.
REQ-024 SHALL drive all outputs from registers, so lfsr_load and lfsr_en are glitch-free single-cycle pulses with no combinational path from inputs.

Reset
REQ-025 SHALL, on rst sampled high at a clock edge, enter IDLE and clear all outputs and counters to 0 on that edge; rst overrides all commands, including mid-RUN or mid-LOAD.

Structure
REQ-026 SHALL take the FSM state enumeration, LFSR_W default, seed substitute value 1 and period constant 255 from shared package lfsr_pkg.
REQ-027 SHALL instantiate one sub-module, tick_gen (TICK_DIV-cycle prescaler with enable and synchronous clear), for the tick counter.

Verification (bench uses TICK_DIV=4 and a behavioural 8-bit Fibonacci LFSR model, taps 8,6,5,4)
REQ-028 SHALL cover: rst, sw=8'h01, start pulse -> lfsr_load high 1 cycle, lfsr_seed=8'h01, running=1, lfsr_en every 4th cycle, step_cnt=3 after 12 RUN cycles.
REQ-029 SHALL cover: sw=8'h00, start -> lfsr_seed=8'h01, never 8'h00.
REQ-030 SHALL cover: stop at step_cnt=5, then 3 step pulses -> exactly 3 lfsr_en, step_cnt=8, no other strobes; start -> running=1, RUN resumes.
REQ-031 SHALL cover: run 255 steps -> single period_done pulse, step_cnt=0, seq_err=0; repeat with the model's lfsr_q forced to 8'hFF at wrap -> seq_err=1 and held.
REQ-032 SHALL cover: stop coincident with tick -> no lfsr_en, state PAUSE; start+stop same cycle in IDLE -> stays IDLE.
REQ-033 SHALL cover: rst asserted mid-RUN -> next cycle every output 0 and state IDLE.
